// File: rtl/spi_slave_if_if.sv
// Pin-side SPI signals and core-side byte handshake bundled for spi_slave_if.
// The slave modport is the front end's view; master is the driving side.
interface spi_slave_if_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  spi_sclk;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_rdy;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_load;
    logic                  busy;
    logic                  tx_underrun;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_load,
        output spi_miso, spi_miso_oe, rx_data, rx_rdy, busy, tx_underrun
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, tx_data, tx_load,
        input  spi_miso, spi_miso_oe, rx_data, rx_rdy, busy, tx_underrun
    );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: oversampled pins, MSB-first byte RX with a
// one-cycle ready strobe, and a buffered TX byte shifted out on MISO.
module spi_slave_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_if_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int FW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_STAGES);
    localparam logic [FW-1:0] FILL_ONE = FW'(1);

    typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;
    state_t state_r, state_nx;

    logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
    logic                   sclk_hist_r, cs_hist_r;
    logic [FW-1:0]          fill_r;
    logic                   armed_r;
    logic [CW-1:0]          bit_cnt_r;
    logic [DATA_WIDTH-1:0]  rx_shift_r, rx_data_r, tx_buf_r, tx_shift_r;
    logic                   tx_valid_r, done_r, rx_rdy_r, underrun_r;
    logic                   miso_r, miso_oe_r;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
    logic start_s, end_s, active_s, bit_rise_s, bit_fall_s;
    logic byte_done_s, shift_load_s;
    logic [DATA_WIDTH-1:0] rx_next_s;

    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s   = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    assign sclk_rise_s = sclk_s & ~sclk_hist_r;
    assign sclk_fall_s = ~sclk_s & sclk_hist_r;
    // A CS fall only counts once a genuine high has been seen since reset
    assign cs_fall_s   = ~cs_s & cs_hist_r & armed_r;
    assign cs_rise_s   = cs_s & ~cs_hist_r;

    assign start_s      = (state_r == ST_IDLE) & cs_fall_s;
    assign end_s        = (state_r == ST_ACTIVE) & cs_rise_s;
    assign active_s     = (state_r == ST_ACTIVE) & ~cs_rise_s;
    assign bit_rise_s   = active_s & sclk_rise_s;
    assign bit_fall_s   = active_s & sclk_fall_s;
    assign byte_done_s  = bit_rise_s & (bit_cnt_r == BIT_LAST);
    assign shift_load_s = start_s | (bit_fall_s & (bit_cnt_r == CNT_ZERO));
    assign rx_next_s    = {rx_shift_r[DATA_WIDTH-2:0], mosi_s};

    // Input synchronisers, edge history and post-reset CS arming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_hist_r <= 1'b0;
            cs_hist_r   <= 1'b1;
            fill_r      <= {FW{1'b0}};
            armed_r     <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.spi_sclk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_hist_r <= sclk_s;
            cs_hist_r   <= cs_s;
            if (fill_r != FILL_MAX) begin
                fill_r <= fill_r + FILL_ONE;
            end
            armed_r <= armed_r | ((fill_r == FILL_MAX) & cs_s);
        end
    end

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Frame next-state logic
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_nx = ST_ACTIVE;
                else         state_nx = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (cs_rise_s) state_nx = ST_IDLE;
                else           state_nx = ST_ACTIVE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Bit counter, RX deserialiser, TX buffer/shifter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r  <= CNT_ZERO;
            rx_shift_r <= {DATA_WIDTH{1'b0}};
            rx_data_r  <= {DATA_WIDTH{1'b0}};
            tx_buf_r   <= {DATA_WIDTH{1'b0}};
            tx_shift_r <= {DATA_WIDTH{1'b0}};
            tx_valid_r <= 1'b0;
            done_r     <= 1'b0;
            rx_rdy_r   <= 1'b0;
            underrun_r <= 1'b0;
            miso_r     <= 1'b0;
            miso_oe_r  <= 1'b0;
        end else begin
            done_r     <= byte_done_s;
            rx_rdy_r   <= done_r;
            underrun_r <= 1'b0;
            miso_r     <= (state_r == ST_ACTIVE) ? tx_shift_r[DATA_WIDTH-1] : 1'b0;
            miso_oe_r  <= (state_r == ST_ACTIVE);

            if (start_s || end_s) begin
                bit_cnt_r <= CNT_ZERO;
            end else if (bit_rise_s) begin
                bit_cnt_r <= (bit_cnt_r == BIT_LAST) ? CNT_ZERO : bit_cnt_r + CNT_ONE;
            end

            if (bit_rise_s) begin
                rx_shift_r <= rx_next_s;
            end
            if (byte_done_s) begin
                rx_data_r <= rx_next_s;
            end

            // A load coinciding with a slot start bypasses the buffer
            if (shift_load_s) begin
                tx_valid_r <= 1'b0;
                if (bus.tx_load) begin
                    tx_shift_r <= bus.tx_data;
                end else if (tx_valid_r) begin
                    tx_shift_r <= tx_buf_r;
                end else begin
                    tx_shift_r <= {DATA_WIDTH{1'b0}};
                    underrun_r <= 1'b1;
                end
            end else begin
                if (bit_fall_s) begin
                    tx_shift_r <= {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
                end
                if (bus.tx_load) begin
                    tx_buf_r   <= bus.tx_data;
                    tx_valid_r <= 1'b1;
                end
            end
        end
    end

    assign bus.spi_miso    = miso_r;
    assign bus.spi_miso_oe = miso_oe_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_rdy      = rx_rdy_r;
    assign bus.busy        = (state_r == ST_ACTIVE);
    assign bus.tx_underrun = underrun_r;
endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: a mode-0 SPI master with a reference
// model of the TX buffer feeding expected RX/MISO bytes and underrun counts.
module tb_spi_slave_if;
    localparam int DW   = 8;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;

    spi_slave_if_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave_if #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         urun_cnt  = 0;
    int         exp_urun  = 0;
    int         rx_seen   = 0;
    int         rx_pushed = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] miso_exp_q[$];
    logic       mdl_valid = 1'b0;
    logic [7:0] mdl_buf   = 8'h00;
    logic [7:0] last_rx   = 8'h00;
    logic       rx_prev   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Output monitor: pops the RX scoreboard on every ready strobe
    always @(negedge clk) begin
        if (bus.tx_underrun === 1'b1) urun_cnt++;
        if (bus.rx_rdy === 1'b1) begin
            rx_seen++;
            check("rx_rdy_pulse", {31'd0, rx_prev}, 32'd0);
            check("rx_count", rx_seen, rx_pushed);
            if (rx_exp_q.size() > 0) check("rx_data", {24'd0, bus.rx_data}, {24'd0, rx_exp_q.pop_front()});
        end
        rx_prev = bus.rx_rdy;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_load(input logic [7:0] lv);
        bus.tx_data = lv;
        bus.tx_load = 1'b1;
        wait_clk(1);
        bus.tx_load = 1'b0;
        mdl_buf   = lv;
        mdl_valid = 1'b1;
    endtask

    task automatic slot_model();
        if (mdl_valid) begin
            miso_exp_q.push_back(mdl_buf);
        end else begin
            miso_exp_q.push_back(8'h00);
            exp_urun++;
        end
        mdl_valid = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_miso"}, {31'd0, bus.spi_miso}, 32'd0);
        check({tag, "_oe"}, {31'd0, bus.spi_miso_oe}, 32'd0);
        check({tag, "_rx_data"}, {24'd0, bus.rx_data}, 32'd0);
        check({tag, "_rx_rdy"}, {31'd0, bus.rx_rdy}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_underrun"}, {31'd0, bus.tx_underrun}, 32'd0);
    endtask

    task automatic cs_start();
        bus.spi_cs_n = 1'b0;
        slot_model();
        wait_clk(HALF);
        check("busy_start", {31'd0, bus.busy}, 32'd1);
        check("oe_start", {31'd0, bus.spi_miso_oe}, 32'd1);
    endtask

    task automatic cs_end();
        wait_clk(HALF);
        bus.spi_cs_n = 1'b1;
        miso_exp_q.delete();
        wait_clk(HALF);
        check("busy_end", {31'd0, bus.busy}, 32'd0);
        check("oe_end", {31'd0, bus.spi_miso_oe}, 32'd0);
        check("miso_end", {31'd0, bus.spi_miso}, 32'd0);
        check("rx_data_hold", {24'd0, bus.rx_data}, {24'd0, last_rx});
        check("underrun_cnt", urun_cnt, exp_urun);
    endtask

    // mode 0: no load, 1: load lv after rx_rdy, 2: load lv coincident with slot load
    task automatic spi_byte(input logic [7:0] mo, input int nbits, input int mode, input logic [7:0] lv);
        logic [7:0] mi;
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.spi_mosi = mo[i];
            wait_clk(HALF);
            mi[i] = bus.spi_miso;
            if (i == 0) begin
                rx_exp_q.push_back(mo);
                rx_pushed++;
                last_rx = mo;
            end
            bus.spi_sclk = 1'b1;
            if (i == 0 && mode == 1) begin
                wait_clk(5);
                host_load(lv);
                wait_clk(HALF - 6);
            end else begin
                wait_clk(HALF);
            end
            bus.spi_sclk = 1'b0;
        end
        if (nbits == 8) begin
            check("miso_q_size", miso_exp_q.size(), 1);
            if (miso_exp_q.size() > 0) check("miso_byte", {24'd0, mi}, {24'd0, miso_exp_q.pop_front()});
            if (mode == 2) begin
                wait_clk(2);
                bus.tx_data = lv;
                bus.tx_load = 1'b1;
                wait_clk(1);
                bus.tx_load = 1'b0;
                miso_exp_q.push_back(lv);
                mdl_valid = 1'b0;
            end else begin
                slot_model();
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_load  = 1'b0;
        #1;
        reset_checks("por");
        wait_clk(3);
        rst = 1'b0;
        wait_clk(10);

        // Reset mid-frame, then SCLK with CS held low must be ignored
        cs_start();
        spi_byte(8'hF0, 4, 0, 8'h00);
        rst = 1'b1;
        #1;
        reset_checks("rst_mid");
        mdl_valid = 1'b0;
        miso_exp_q.delete();
        wait_clk(3);
        rst = 1'b0;
        wait_clk(10);
        check("busy_after_rst", {31'd0, bus.busy}, 32'd0);
        repeat (8) begin
            bus.spi_sclk = 1'b1;
            wait_clk(HALF);
            bus.spi_sclk = 1'b0;
            wait_clk(HALF);
        end
        check("busy_no_cs_fall", {31'd0, bus.busy}, 32'd0);
        bus.spi_cs_n = 1'b1;
        wait_clk(HALF);
        cs_start();
        spi_byte(8'hA5, 8, 0, 8'h00);
        cs_end();

        // Single byte with a preloaded reply
        host_load(8'h3C);
        wait_clk(2);
        cs_start();
        spi_byte(8'hA5, 8, 0, 8'h00);
        cs_end();

        // Back-to-back bytes, reply loaded after each ready strobe
        host_load(8'h3C);
        wait_clk(2);
        cs_start();
        spi_byte(8'h01, 8, 1, 8'h11);
        spi_byte(8'h80, 8, 1, 8'h22);
        spi_byte(8'hFF, 8, 0, 8'h00);
        cs_end();

        // Underrun in the second slot
        host_load(8'h42);
        wait_clk(2);
        cs_start();
        spi_byte(8'h12, 8, 0, 8'h00);
        spi_byte(8'h34, 8, 0, 8'h00);
        cs_end();

        // Aborted byte, then a clean frame
        cs_start();
        spi_byte(8'hC3, 5, 0, 8'h00);
        cs_end();
        cs_start();
        spi_byte(8'h5A, 8, 0, 8'h00);
        cs_end();

        // Load coincident with a slot load
        host_load(8'h99);
        wait_clk(2);
        cs_start();
        spi_byte(8'h66, 8, 2, 8'h77);
        spi_byte(8'h88, 8, 0, 8'h00);
        cs_end();

        wait_clk(20);
        check("rx_q_drained", rx_exp_q.size(), 0);
        check("rx_total", rx_seen, rx_pushed);
        check("underrun_total", urun_cnt, exp_urun);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit, errors so far %0d", n_errors);
        $fatal(1);
    end
endmodule
